// File: rtl/aes_io_pkg.sv
// Shared types and constants for the word-serial AES front-end.
package aes_io_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } aes_state_e;

    // True when a beat width tiles the AES block exactly.
    function automatic bit word_w_ok(input int unsigned w);
        return (w != 0) && (w <= AES_BLK_W) && ((AES_BLK_W % w) == 0);
    endfunction

endpackage

// File: rtl/aes_word_shreg.sv
// 128-bit register that loads in parallel or shifts left by one WORD_W beat.
module aes_word_shreg
    import aes_io_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WORD_W-1:0]    din,
    input  logic [AES_BLK_W-1:0] par_in,
    output logic [AES_BLK_W-1:0] par_out
);

    logic [AES_BLK_W-1:0] data_q;
    logic [AES_BLK_W-1:0] data_d;
    logic [AES_BLK_W-1:0] shifted;

    // A full-width beat replaces the whole block; narrower beats enter at the LSB end.
    if (WORD_W >= AES_BLK_W) begin : g_full
        assign shifted = AES_BLK_W'(din);
    end else begin : g_part
        assign shifted = {data_q[AES_BLK_W-WORD_W-1:0], din};
    end

    // Next value: parallel load wins over shift.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = par_in;
        end else if (shift) begin
            data_d = shifted;
        end
    end

    // Block register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-serial valid/ready front-end for a 128-bit AES core with key reuse,
// done-protocol error flag and WAIT-state watchdog.
module aes_stream_adapter
    import aes_io_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_key,
    input  logic [WORD_W-1:0]    in_text,
    input  logic                 key_keep,
    output logic                 core_ld,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_text,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_text_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_done,
    output logic                 err_timeout
);

    localparam int unsigned NBEATS = AES_BLK_W / WORD_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    // Reject beat widths that do not tile the block.
    if (!word_w_ok(WORD_W)) begin : g_bad_word_w
        $error("aes_stream_adapter: WORD_W must divide 128");
    end

    aes_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wcnt_q, wcnt_d;
    logic             keep_q, keep_d;
    logic             err_done_q, err_done_d;
    logic             err_timeout_q, err_timeout_d;

    logic             keep_now;
    logic             key_shift;
    logic             text_shift;
    logic             out_load;
    logic             out_shift;
    logic [AES_BLK_W-1:0] out_reg;

    // Keep decision comes from the pin on the first beat, from the latch afterwards.
    assign keep_now = (cnt_q == '0) ? key_keep : keep_q;

    // Next-state, beat counting, watchdog and error flags.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        keep_d        = keep_q;
        err_done_d    = err_done_q;
        err_timeout_d = err_timeout_q;
        key_shift     = 1'b0;
        text_shift    = 1'b0;
        out_load      = 1'b0;
        out_shift     = 1'b0;

        if (core_done && (state_q != WAIT)) begin
            err_done_d = 1'b1;
        end

        case (state_q)
            LOAD: begin
                wcnt_d = '0;
                if (in_valid && in_ready) begin
                    text_shift = 1'b1;
                    key_shift  = !keep_now;
                    if (cnt_q == '0) begin
                        keep_d = key_keep;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = FIRE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIRE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    out_load = 1'b1;
                    wcnt_d   = '0;
                    state_d  = DRAIN;
                end else if (TIMEOUT > 0) begin
                    wcnt_d = wcnt_q + WD_W'(1);
                    if (wcnt_d == WD_LIMIT) begin
                        err_timeout_d = 1'b1;
                        wcnt_d        = '0;
                        state_d       = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_shift = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            cnt_q         <= '0;
            wcnt_q        <= '0;
            keep_q        <= 1'b0;
            err_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wcnt_q        <= wcnt_d;
            keep_q        <= keep_d;
            err_done_q    <= err_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    aes_word_shreg #(.WORD_W(WORD_W)) u_key_sr (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b0),
        .shift   (key_shift),
        .din     (in_key),
        .par_in  ('0),
        .par_out (core_key)
    );

    aes_word_shreg #(.WORD_W(WORD_W)) u_text_sr (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b0),
        .shift   (text_shift),
        .din     (in_text),
        .par_in  ('0),
        .par_out (core_text)
    );

    aes_word_shreg #(.WORD_W(WORD_W)) u_out_sr (
        .clk     (clk),
        .rst     (rst),
        .load    (out_load),
        .shift   (out_shift),
        .din     ('0),
        .par_in  (core_text_out),
        .par_out (out_reg)
    );

    // Handshake and status outputs are pure decodes of registered state;
    // in_ready is held low while reset is asserted.
    assign in_ready    = (state_q == LOAD) && !rst;
    assign core_ld     = (state_q == FIRE);
    assign out_valid   = (state_q == DRAIN);
    assign out_last    = (state_q == DRAIN) && (cnt_q == CNT_LAST);
    assign out_data    = out_reg[AES_BLK_W-1 -: WORD_W];
    assign busy        = (state_q != LOAD);
    assign err_done    = err_done_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Randomised self-checking bench: three adapter configurations run in parallel,
// each against a block-level reference of key reuse, result order and timing.
module tb_aes_stream_adapter;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in core: the real FIPS-197 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned W  = (g == 0) ? 32 : ((g == 1) ? 8 : 128);
        localparam int unsigned TO = (g == 0) ? 20 : 0;
        localparam int unsigned NB = 128 / W;

        logic           rst = 1'b1;
        logic           in_valid = 1'b0;
        logic           in_ready;
        logic [W-1:0]   in_key = '0;
        logic [W-1:0]   in_text = '0;
        logic           key_keep = 1'b0;
        logic           core_ld;
        logic [127:0]   core_key;
        logic [127:0]   core_text;
        logic           core_done = 1'b0;
        logic [127:0]   core_text_out = '0;
        logic           out_valid;
        logic           out_ready = 1'b0;
        logic [W-1:0]   out_data;
        logic           out_last;
        logic           busy;
        logic           err_done;
        logic           err_timeout;
        logic [127:0]   stored_key = '0;
        logic           fin = 1'b0;

        aes_stream_adapter #(.WORD_W(W), .TIMEOUT(TO)) dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid),
            .in_ready      (in_ready),
            .in_key        (in_key),
            .in_text       (in_text),
            .key_keep      (key_keep),
            .core_ld       (core_ld),
            .core_key      (core_key),
            .core_text     (core_text),
            .core_done     (core_done),
            .core_text_out (core_text_out),
            .out_valid     (out_valid),
            .out_ready     (out_ready),
            .out_data      (out_data),
            .out_last      (out_last),
            .busy          (busy),
            .err_done      (err_done),
            .err_timeout   (err_timeout)
        );

        function automatic string tg(input string s);
            return $sformatf("w%0d_%s", W, s);
        endfunction

        task automatic do_reset(input int cycles);
            rst = 1'b1; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0; key_keep = 1'b0;
            @(negedge clk);
            check(tg("rst_in_ready"), 128'(in_ready), 128'(0));
            check(tg("rst_status"), 128'({core_ld, out_valid, out_last, busy, err_done, err_timeout}), 128'(0));
            check(tg("rst_core_key"), core_key, 128'(0));
            check(tg("rst_out_data"), 128'(out_data), 128'(0));
            repeat (cycles - 1) @(negedge clk);
            rst = 1'b0;
            stored_key = '0;
            @(negedge clk);
            check(tg("post_rst_ready"), 128'(in_ready), 128'(1));
            check(tg("post_rst_err"), 128'({err_done, err_timeout}), 128'(0));
        endtask

        task automatic send_beats(input logic [127:0] key, input logic [127:0] text,
                                  input logic keep, input int nbeats);
            int gap;
            int gd;
            for (int b = 0; b < nbeats; b++) begin
                gap = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
                in_valid = 1'b1;
                in_key   = key[127 - W*b -: W];
                in_text  = text[127 - W*b -: W];
                key_keep = (b == 0) ? keep : 1'($urandom);
                gd = 0;
                while (!in_ready && gd < 50) begin
                    @(negedge clk);
                    gd++;
                end
                if (gd >= 50) check(tg("in_ready_wait"), 128'(in_ready), 128'(1));
                @(negedge clk);
            end
            in_valid = 1'b0;
            key_keep = 1'b0;
        endtask

        // Called on the negedge right after the last input beat was taken.
        task automatic check_fire(input logic [127:0] k, input logic [127:0] t);
            check(tg("core_ld_pulse"), 128'(core_ld), 128'(1));
            check(tg("core_key"), core_key, k);
            check(tg("core_text"), core_text, t);
            check(tg("busy_fire"), 128'(busy), 128'(1));
            @(negedge clk);
            check(tg("core_ld_single"), 128'(core_ld), 128'(0));
        endtask

        task automatic drain(input logic [127:0] res, input bit bp);
            int idx;
            int hold;
            int gd;
            logic [127:0] sh;
            logic rdy;
            idx = 0; hold = 0; gd = 0;
            while (idx < NB && gd < 2000) begin
                sh = res << (W * idx);
                check(tg("out_valid"), 128'(out_valid), 128'(1));
                check(tg("out_data"), 128'(out_data), 128'(sh[127 -: W]));
                check(tg("out_last"), 128'(out_last), 128'(idx == NB - 1));
                if (bp) begin
                    rdy  = (hold == 5);
                    hold = rdy ? 0 : hold + 1;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                out_ready = rdy;
                @(negedge clk);
                if (rdy) idx++;
                gd++;
            end
            out_ready = 1'b0;
            check(tg("drain_count"), 128'(idx), 128'(NB));
            check(tg("after_drain_ready"), 128'(in_ready), 128'(1));
            check(tg("after_drain_idle"), 128'({out_valid, busy}), 128'(0));
        endtask

        // Called on a negedge in WAIT; the core answers from what the adapter presented.
        task automatic respond(input logic [127:0] exp_res, input int dly, input bit bp);
            repeat (dly) begin
                check(tg("wait_no_valid"), 128'(out_valid), 128'(0));
                @(negedge clk);
            end
            core_done = 1'b1;
            core_text_out = core_f(core_key, core_text);
            @(negedge clk);
            core_done = 1'b0;
            core_text_out = rand128();
            drain(exp_res, bp);
        endtask

        task automatic run_block(input logic [127:0] key, input logic [127:0] text,
                                 input logic keep, input bit bp);
            logic [127:0] exp_key;
            exp_key = keep ? stored_key : key;
            stored_key = exp_key;
            send_beats(key, text, keep, NB);
            check_fire(exp_key, text);
            respond(core_f(exp_key, text), $urandom_range(0, 5), bp);
        endtask

        task automatic err_done_test();
            core_done = 1'b1;
            core_text_out = rand128();
            @(negedge clk);
            core_done = 1'b0;
            check(tg("err_done_set"), 128'(err_done), 128'(1));
            check(tg("err_done_stay_load"), 128'({in_ready, busy, out_valid}), 128'(3'b100));
        endtask

        task automatic watchdog_test(input logic [127:0] key, input logic [127:0] text);
            int lim;
            logic expect_to;
            stored_key = key;
            send_beats(key, text, 1'b0, NB);
            check_fire(key, text);
            lim = (TO > 0) ? TO + 1 : 30;
            for (int i = 1; i <= lim; i++) begin
                expect_to = (TO > 0) && (i == TO + 1);
                check(tg("wd_err_timeout"), 128'(err_timeout), 128'(expect_to));
                check(tg("wd_in_ready"), 128'(in_ready), 128'(expect_to));
                if (i < lim) @(negedge clk);
            end
            if (TO == 0) respond(core_f(key, text), 0, 1'b0);
        endtask

        initial begin
            do_reset(2);
            run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
            run_block({128{1'b1}}, FIPS_PT, 1'b1, 1'b0);
            run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b1);
            repeat (6) run_block(rand128(), rand128(), 1'($urandom), 1'b0);
            err_done_test();
            do_reset(1);
            run_block(rand128(), rand128(), 1'b1, 1'b0);
            send_beats(rand128(), rand128(), 1'b0, (NB > 2) ? 2 : 0);
            do_reset(1);
            run_block(rand128(), rand128(), 1'b0, 1'b0);
            watchdog_test(rand128(), rand128());
            run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
            check(tg("err_timeout_sticky"), 128'(err_timeout), 128'(TO > 0));
            fin = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && cyc < 80000) begin
            @(posedge clk);
            cyc++;
        end
        check("bench_complete", 128'({g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}), 128'(3'b111));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
